pipe_stage_reg: RTL and testbench

- Generic, parametrised pipeline-boundary register for the 5-stage CPU; replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data bundle under a valid/ready handshake, with a 2-entry skid buffer and a synchronous flush.
- Flush inserts a bubble.
- Upstream hazard logic drives flush; a downstream stall deasserts out_ready.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_sat_cnt.sv | 27 ++
 rtl/pipe_stage_reg.sv | 149 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : pipe_pkg
//  Purpose  : Shared types and constants for the pipeline-boundary register.
//  Revision : 1.0  initial release
// ============================================================================
package pipe_pkg;

    // Occupancy of a pipeline stage (main register plus skid register)
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    // Width and ceiling of the performance counters
    localparam int                    PIPE_CNT_W   = 32;
    localparam logic [PIPE_CNT_W-1:0] PIPE_CNT_MAX = {PIPE_CNT_W{1'b1}};

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_sat_cnt
//  Purpose  : Enabled up-counter that sticks at its maximum value.
//             Cleared only by the asynchronous active-low reset.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_sat_cnt
    import pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic [PIPE_CNT_W-1:0] count
);

    // Count enabled cycles, holding once the ceiling is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != PIPE_CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule : pipe_sat_cnt
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Parametrised pipeline-boundary register with valid/ready
//             handshake, 2-entry skid buffer and synchronous flush.
//             Define PIPE_STAGE_PERF_EN to add stall/bubble counters.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = 96,
    parameter int                CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_W-1:0]     out_ctrl,
`ifdef PIPE_STAGE_PERF_EN
    output logic [PIPE_CNT_W-1:0] stall_cnt,
    output logic [PIPE_CNT_W-1:0] bubble_cnt,
`endif
    output logic [DATA_W-1:0]     out_data
);

    pipe_state_t       state;
    pipe_state_t       state_nxt;
    logic              accept;
    logic              deliver;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;
    logic              bubble_main;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign accept  = in_valid & in_ready;
    assign deliver = out_valid & out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: flush overrides every handshake
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (accept) state_nxt = ONE;
                ONE: begin
                    if (accept && !deliver)      state_nxt = FULL;
                    else if (!accept && deliver) state_nxt = EMPTY;
                end
                FULL:    if (deliver) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Handshake outputs depend on the registered state only
    always_comb begin
        in_ready  = (state != FULL);
        out_valid = (state != EMPTY);
    end

    // Datapath steering: which register loads from where this cycle
    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        bubble_main    = 1'b0;
        case (state)
            EMPTY: load_main_in = accept;
            ONE: begin
                load_main_in = accept & deliver;
                load_skid    = accept & ~deliver;
                bubble_main  = ~accept & deliver;
            end
            FULL:    load_main_skid = deliver;
            default: ;
        endcase
    end

    // Main and skid registers; an emptied main keeps its data but shows a no-op control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_ctrl <= BUBBLE_CTRL;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (flush) begin
            main_ctrl <= BUBBLE_CTRL;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            if (load_main_in) begin
                main_ctrl <= in_ctrl;
                main_data <= in_data;
            end else if (load_main_skid) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end else if (bubble_main) begin
                main_ctrl <= BUBBLE_CTRL;
            end
            if (load_skid) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end
        end
    end

    assign out_ctrl = main_ctrl;
    assign out_data = main_data;

`ifdef PIPE_STAGE_PERF_EN
    pipe_sat_cnt u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (out_valid & ~out_ready),
        .count (stall_cnt)
    );

    pipe_sat_cnt u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (~out_valid),
        .count (bubble_cnt)
    );
`endif

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_reg
//  Purpose  : Scoreboard bench for pipe_stage_reg. Accepted entries are
//             queued by the driver; the monitor checks every cycle against
//             a 2-deep FIFO view of the stage.
//             Honours PIPE_STAGE_PERF_EN for the counter ports.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int          DATA_W = 96;
    localparam int          CTRL_W = 16;
    localparam logic [15:0] BUBBLE = 16'h8001;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       bubble_cnt;
`endif

    pipe_stage_reg #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .BUBBLE_CTRL (BUBBLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
`ifdef PIPE_STAGE_PERF_EN
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt),
`endif
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    // Model: entries the stage currently owns, oldest first
    entry_t            q[$];
    logic [DATA_W-1:0] idle_data = '0;
    int                acc_pend  = 0;
    bit                mon_en    = 1'b0;
    int                checks    = 0;
    int                passed    = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    // Drive one cycle of inputs (called at posedge+1) and record an accept
    task automatic step(input bit v, input bit r, input bit f,
                        input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        in_valid  = v;
        out_ready = r;
        flush     = f;
        in_ctrl   = c;
        in_data   = d;
        if (v && in_ready && !f) begin
            q.push_back({c, d});
            acc_pend = 1;
        end else begin
            acc_pend = 0;
        end
        @(posedge clk);
        #1;
        acc_pend = 0;
    endtask

    // Monitor: compare presented outputs with the model, retire delivered entries
    always @(negedge clk) begin
        int occ;
        if (mon_en && rst_n) begin
            occ = q.size() - acc_pend;
            chk("in_ready", 128'(in_ready), 128'(occ < 2));
            chk("out_valid", 128'(out_valid), 128'(occ > 0));
            if (occ > 0) begin
                chk("out_ctrl", 128'(out_ctrl), 128'(q[0].ctrl));
                chk("out_data", 128'(out_data), 128'(q[0].data));
                if (out_valid && out_ready) begin
                    idle_data = q[0].data;
                    void'(q.pop_front());
                end
            end else begin
                chk("bubble_ctrl", 128'(out_ctrl), 128'(BUBBLE));
                chk("idle_data", 128'(out_data), 128'(idle_data));
            end
            if (flush) begin
                q.delete();
                idle_data = '0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef PIPE_STAGE_PERF_EN
        logic [31:0] s0, b0;
`endif
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_ctrl", 128'(out_ctrl), 128'(BUBBLE));
        chk("rst_out_data", 128'(out_data), 128'(0));
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Streaming 1,2,3 with downstream always ready
        for (int i = 1; i <= 3; i++) step(1, 1, 0, CTRL_W'(i), DATA_W'(i));
        repeat (2) step(0, 1, 0, '0, '0);

        // Back-pressure fills the skid, C is held off until space frees
        step(1, 0, 0, 16'h0005, 96'hA);
        step(1, 0, 0, 16'h0006, 96'hB);
        chk("full_in_ready", 128'(in_ready), 128'(0));
        step(1, 0, 0, 16'h0007, 96'hC);
        step(1, 1, 0, 16'h0007, 96'hC);
        step(1, 1, 0, 16'h0007, 96'hC);
        repeat (3) step(0, 1, 0, '0, '0);

        // Flush while FULL with a new entry offered
        step(1, 0, 0, 16'h0011, 96'h11);
        step(1, 0, 0, 16'h0012, 96'h12);
        step(1, 0, 1, 16'h0013, 96'h13);
        chk("flush_out_valid", 128'(out_valid), 128'(0));
        chk("flush_out_ctrl", 128'(out_ctrl), 128'(BUBBLE));
        chk("flush_out_data", 128'(out_data), 128'(0));
        chk("flush_in_ready", 128'(in_ready), 128'(1));
        repeat (2) step(0, 1, 0, '0, '0);

        // Asynchronous reset mid-cycle while holding one entry
        step(1, 0, 0, 16'h0021, 96'h21);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        q.delete();
        idle_data = '0;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'(0));
        chk("arst_in_ready", 128'(in_ready), 128'(1));
        chk("arst_out_ctrl", 128'(out_ctrl), 128'(BUBBLE));
        chk("arst_out_data", 128'(out_data), 128'(0));
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Flush and accept together while stalled
        step(1, 0, 0, 16'h0031, 96'h31);
        step(1, 0, 1, 16'h0032, 96'h32);
        chk("fa_out_valid", 128'(out_valid), 128'(0));
        chk("fa_in_ready", 128'(in_ready), 128'(1));
        step(0, 1, 0, '0, '0);

        // Randomised traffic
        repeat (400)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0, CTRL_W'($urandom()), rnd_data());
        for (int i = 0; i < 10 && q.size() > 0; i++) step(0, 1, 0, '0, '0);

`ifdef PIPE_STAGE_PERF_EN
        step(0, 1, 0, '0, '0);
        step(1, 0, 0, 16'h0041, 96'h41);
        s0 = stall_cnt;
        repeat (3) step(0, 0, 0, '0, '0);
        chk("stall_delta", 128'(stall_cnt - s0), 128'(3));
        step(0, 1, 0, '0, '0);
        b0 = bubble_cnt;
        repeat (2) step(0, 1, 0, '0, '0);
        chk("bubble_delta", 128'(bubble_cnt - b0), 128'(2));
        step(1, 0, 0, 16'h0042, 96'h42);
        force dut.u_stall_cnt.count = 32'hFFFF_FFFE;
        #1;
        release dut.u_stall_cnt.count;
        repeat (3) step(0, 0, 0, '0, '0);
        chk("stall_saturate", 128'(stall_cnt), 128'(32'hFFFF_FFFF));
        step(0, 1, 0, '0, '0);
`endif

        for (int i = 0; i < 10 && q.size() > 0; i++) step(0, 1, 0, '0, '0);
        chk("drain_empty", 128'(q.size()), 128'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_pipe_stage_reg
`default_nettype wire
